digit_serial_addsub: RTL
========================

Name: digit_serial_addsub

Overview:
- Parametrised two's-complement adder/subtractor processing CHUNK bits per clock, LSB chunk first, with a registered carry between chunks.
- Generalises the team's fixed 6-bit ripple add/sub in three ways: width is parametrised, operands are latched on a start handshake, and result and flags (carry, overflow, zero, negative) are held in registers.
- Sits between operand registers/switch inputs and the display/ALU result path wherever a narrow, area-cheap adder is acceptable.

Parameters:
- WIDTH, 12, operand/result width in bits; must be a multiple of CHUNK and at least 2.
- CHUNK, 4, bits added per clock cycle; 1 ≤ CHUNK ≤ WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- sel  input  1  0 = add (x+y), 1 = subtract (x−y); latched with operands.
- x  input  WIDTH  operand A; latched when start is accepted.
- y  input  WIDTH  operand B; latched when start is accepted.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; result and flags valid from this cycle.
- sum  output  WIDTH  registered result.
- c_out  output  1  carry out of MSB; for subtract, 1 = no borrow.
- overflow  output  1  signed overflow.
- zero  output  1  sum == 0.
- negative  output  1  sum[WIDTH-1].

Behaviour:
- Reset: the block is asynchronous, active-high. It forces state IDLE and clears chunk index, carry register, operand registers, sum, c_out, overflow, zero, negative, done and busy to 0. Reset mid-RUN abandons the operation; no done pulse follows.
- NCH = WIDTH/CHUNK.
- FSM:
  - IDLE: when start=1 at a rising edge, latch x, y and sel; load y_reg with y XOR {WIDTH{sel}}; load carry register with sel; set idx=0; go to RUN. Otherwise stay in IDLE.
  - RUN: each edge adds chunk idx of x_reg, y_reg and the carry register through the chunk adder. Write the chunk sum into the partial-result register, update the carry register, increment idx.
    - On the edge that processes idx=NCH-1, also load sum, c_out and the flags, then go to DONE.
  - DONE: done=1 for exactly this one cycle, then IDLE unconditionally.
- start is ignored in RUN and DONE; it is not queued.
- Latency: start accepted at edge E, done high in the cycle following edge E+NCH. Back-to-back throughput is one operation per NCH+2 cycles.
- sum and flags hold their value from done until the next operation's final RUN edge. They never show partial results.
- Arithmetic is modulo 2^WIDTH.
  - overflow = (carry into MSB) XOR (carry out of MSB), both taken from the final chunk.
  - zero and negative are computed from the final assembled sum.
- With CHUNK=WIDTH, NCH=1 (single RUN cycle). The degenerate idx width (1 bit) must synthesise cleanly.
- x, y and sel changing during RUN has no effect.

Decomposition:
- Shared package (addsub_pkg):
  - state encoding constants ST_IDLE, ST_RUN, ST_DONE;
  - SEL_ADD=0, SEL_SUB=1;
  - a function clog2 for sizing the idx counter.
- Sub-module chunk_adder (parameter CHUNK), purely combinational ripple of CHUNK full-adder cells.
  - Inputs: a[CHUNK], b[CHUNK], cin.
  - Outputs: s[CHUNK], cout, c_msb_in (carry into bit CHUNK-1).
- Top level holds the FSM, operand/carry/idx registers and flag logic.

Test Plan (WIDTH=12, CHUNK=4):
- Add 100+27, sel=0 → done at cycle after E+3; sum=127, c_out=0, overflow=0, zero=0, negative=0, busy high 4 cycles.
- Subtract 5−7, sel=1 → sum=0xFFE, c_out=0, overflow=0, negative=1.
- Add 0x7FF+0x001 → sum=0x800, overflow=1, c_out=0, negative=1. Subtract 0x800−0x001 → sum=0x7FF, overflow=1, c_out=1.
- Add 0xFFF+0x001 → sum=0x000, zero=1, c_out=1, overflow=0. Subtract 0x123−0x123 → sum=0, zero=1, c_out=1.
- Pulse start again and change x/y while busy → ignored; result matches original operands; only one done pulse. Assert reset mid-RUN → all outputs 0 immediately, no done. A new start afterwards completes normally.
- Re-run the first case with parameters CHUNK=12 and CHUNK=1: same results, latencies 1 and 12 RUN cycles respectively.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
//   state_t  : FSM state encoding (ST_IDLE, ST_RUN, ST_DONE)
//   SEL_ADD / SEL_SUB : meaning of the sel input
//   clog2    : ceiling log2, used to size the chunk index counter
package addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic SEL_ADD = 1'b0;
  localparam logic SEL_SUB = 1'b1;

  // Ceiling log2; returns 0 for v <= 1, callers clamp to a minimum width.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational ripple adder over one chunk of CHUNK bits.
//   a, b     : chunk operands
//   cin      : carry into bit 0
//   s        : chunk sum
//   cout     : carry out of bit CHUNK-1
//   c_msb_in : carry into bit CHUNK-1 (needed for signed overflow)
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = cin;

  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
    assign s[gi]      = a[gi] ^ b[gi] ^ w_c[gi];
    assign w_c[gi+1]  = (a[gi] & b[gi]) | (w_c[gi] & (a[gi] ^ b[gi]));
  end

  assign cout     = w_c[CHUNK];
  assign c_msb_in = w_c[CHUNK-1];

endmodule

// File: rtl/digit_serial_addsub.sv
// Digit-serial two's-complement adder/subtractor, CHUNK bits per clock,
// LSB chunk first, with the inter-chunk carry held in a register.
//   clk, reset : clock (rising edge) and asynchronous active-high reset
//   start      : request, accepted only in IDLE
//   sel        : 0 = x+y, 1 = x-y (captured with the operands)
//   x, y       : operands, captured when start is accepted
//   busy       : high in RUN and DONE
//   done       : one-cycle pulse, result/flags valid from this cycle
//   sum        : registered result
//   c_out      : carry out of MSB (subtract: 1 = no borrow)
//   overflow   : signed overflow
//   zero       : sum == 0
//   negative   : sum[WIDTH-1]
module digit_serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sel,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int NCH   = WIDTH / CHUNK;
  // Keep the index at least 1 bit wide so NCH == 1 still elaborates.
  localparam int IDX_W = (NCH <= 1) ? 1 : clog2(NCH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_part;
  logic [WIDTH-1:0] r_sum;
  logic             r_c_out;
  logic             r_overflow;
  logic             r_zero;
  logic             r_negative;

  logic [CHUNK-1:0] w_a;
  logic [CHUNK-1:0] w_b;
  logic [CHUNK-1:0] w_s;
  logic             w_cout;
  logic             w_c_msb_in;
  logic [WIDTH-1:0] w_part_next;
  logic             w_last;

  chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .a        (w_a),
    .b        (w_b),
    .cin      (r_carry),
    .s        (w_s),
    .cout     (w_cout),
    .c_msb_in (w_c_msb_in)
  );

  // Select the current chunk of each operand and merge the new chunk sum
  // into the partial result. On the final edge w_part_next is the full sum.
  always_comb begin
    w_a         = '0;
    w_b         = '0;
    w_part_next = r_part;
    for (int i = 0; i < NCH; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_a = r_x[i*CHUNK +: CHUNK];
        w_b = r_y[i*CHUNK +: CHUNK];
        w_part_next[i*CHUNK +: CHUNK] = w_s;
      end
    end
  end

  assign w_last = (r_state == ST_RUN) && (r_idx == LAST_IDX);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_next = ST_RUN;
      ST_RUN:  if (r_idx == LAST_IDX) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_carry    <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_part     <= '0;
      r_sum      <= '0;
      r_c_out    <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
      r_negative <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_IDLE && start) begin
        // Subtract is x + ~y + 1: invert y here and seed the carry with 1.
        r_x     <= x;
        r_y     <= y ^ {WIDTH{sel}};
        r_carry <= (sel == SEL_SUB);
        r_idx   <= '0;
      end else if (r_state == ST_RUN) begin
        r_part  <= w_part_next;
        r_carry <= w_cout;
        r_idx   <= r_idx + 1'b1;
        if (w_last) begin
          r_sum      <= w_part_next;
          r_c_out    <= w_cout;
          r_overflow <= w_cout ^ w_c_msb_in;
          r_zero     <= (w_part_next == '0);
          r_negative <= w_part_next[WIDTH-1];
        end
      end
    end
  end

  assign busy     = (r_state == ST_RUN) || (r_state == ST_DONE);
  assign done     = (r_state == ST_DONE);
  assign sum      = r_sum;
  assign c_out    = r_c_out;
  assign overflow = r_overflow;
  assign zero     = r_zero;
  assign negative = r_negative;

endmodule
